stream_mux_n: RTL
=================

# stream_mux_n

Parametrised N-channel, DW-bit registered multiplexer with valid/ready handshake on every input channel and on the output. It is the sequential successor to the team's transistor-level 2:1 MUX. It selects one channel per cycle, either from an explicit select input or by round-robin arbitration, and launches the chosen beat through a one-deep output register. It sits between multiple producer streams and a single consumer, for example when merging lanes into a shared bus.

## Interface
- N_CH, default 4: number of input channels; legal range 2..16.
- DW, default 8: data width per channel, at least 1.
- SW, derived as $clog2(N_CH): width of the select and channel-ID fields.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*DW  channel i occupies bits [i*DW +: DW].
- in_ready  output  N_CH  per-channel ready; at most one bit high per cycle.
- sel  input  SW  channel to pass in select mode.
- rr_en  input  1  1 = round-robin mode, 0 = select mode. Present only with STREAM_MUX_RR_EN.
- out_valid  output  1  output register holds a beat.
- out_data  output  DW  registered data.
- out_ch  output  SW  source channel of the registered beat.
- out_ready  input  1  consumer accepts the beat.
- xfer_cnt  output  16  count of accepted input beats; saturates at 0xFFFF.

## Operation
- **Grant (combinational).** Grant is a single channel index g plus a grant-valid flag.
  - Select mode: g = sel. Grant is valid only if sel < N_CH and in_valid[sel] = 1.
  - Round-robin mode: search channels rr_ptr+1, rr_ptr+2, … modulo N_CH. g is the first channel with in_valid high. Grant is valid if any in_valid is high.
- **Space.** space = !out_valid || out_ready.
- **Ready.** in_ready[g] = grant valid && space. All other in_ready bits are 0.
  - in_ready must not depend on in_valid of the non-selected channels in select mode.
- **Accept.** An input beat is accepted when in_ready[g] && in_valid[g]. On accept:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - xfer_cnt increments unless it is already 0xFFFF.
  - rr_ptr <= g, in round-robin mode only.
- **Drain.** If out_valid && out_ready and there is no accept, out_valid <= 0. out_data and out_ch hold their last values.
- **Simultaneous drain and accept.** The new beat replaces the old one. out_valid stays 1. The output runs at full throughput, one beat per cycle.
- **Stall.** If out_valid && !out_ready, out_data and out_ch are held stable and all in_ready bits are 0.
- **Select changes.** A change of sel or rr_en while stalled affects only the next accept. The beat already registered is never altered.
- **Out-of-range select.** sel >= N_CH (possible only when N_CH is not a power of two): no grant, all in_ready 0. The output register still drains normally.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on out_* after edge k.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, xfer_cnt = 0, rr_ptr = N_CH-1. The rr_ptr value makes the first round-robin search start at channel 0.
- in_ready is 0 during reset, because out_valid = 0 but no grant is taken while rst_n is low.
- Reset asserted mid-transfer discards the registered beat immediately and asynchronously. No partial state survives.
- The consumer sees the first post-reset output no earlier than one edge after rst_n deasserts.

## Configuration
- STREAM_MUX_RR_EN defined:
  - The rr_en port and the rr_ptr register exist.
  - rr_en = 1 selects round-robin arbitration; rr_en = 0 selects select mode.
  - While rr_en = 0, rr_ptr holds its value.
- STREAM_MUX_RR_EN undefined:
  - The rr_en port and rr_ptr are removed.
  - The block operates in select mode only. All other behaviour is identical.

## Test plan
- **Reset.** Hold rst_n = 0 with all inputs active, then release. Required: out_valid = 0, out_data = 0, out_ch = 0, xfer_cnt = 0, in_ready = 0 during reset. The first accept occurs on the edge after release.
- **Select mode, streaming.** N_CH = 4, DW = 8, sel = 2, in_data[2] = 0xA5 valid every cycle, out_ready = 1. Required: in_ready = 4'b0100, out_data = 0xA5 and out_ch = 2 one cycle later, one beat per cycle, xfer_cnt increments by 1 per cycle.
- **Backpressure.** Set out_ready = 0 for 3 cycles with out_valid = 1. Required: out_data and out_ch held stable, in_ready = 0 throughout. When out_ready returns to 1, the drain and the next accept occur in the same cycle.
- **Round-robin fairness (STREAM_MUX_RR_EN).** rr_en = 1, all four channels continuously valid. Required: out_ch sequence 0, 1, 2, 3, 0. With only channels 1 and 3 valid, the sequence is 1, 3, 1, 3.
- **Out-of-range select.** N_CH = 3, sel = 3. Required: in_ready = 0 and xfer_cnt unchanged; a pending output beat still drains.
- **Counter saturation.** Force 65 537 accepts. Required: xfer_cnt stops at 0xFFFF and does not wrap to 0.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with valid/ready on every input and the output.
// Optional round-robin arbitration (rr_en port, rr_ptr register) is built only with STREAM_MUX_RR_EN.
`timescale 1ns/1ps

module stream_mux_n #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SW  = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_ready,
    input  logic [SW-1:0]        sel,
`ifdef STREAM_MUX_RR_EN
    input  logic                 rr_en,
`endif
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_ch,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    logic          grant_ok;
    logic [SW-1:0] grant_ch;
    logic [DW-1:0] grant_data;
    logic          space;
    logic          take;

`ifdef STREAM_MUX_RR_EN
    logic [SW-1:0] rr_ptr;
    int unsigned   rr_idx;
`endif

    always_comb begin
        grant_ok = 1'b0;
        grant_ch = sel;
        // Select mode looks only at the selected channel's valid.
        if (32'(sel) < N_CH) begin
            grant_ok = 1'(in_valid >> sel);
        end
`ifdef STREAM_MUX_RR_EN
        rr_idx = 0;
        if (rr_en) begin
            grant_ok = 1'b0;
            grant_ch = '0;
            // Walk from farthest to nearest so the nearest valid channel after rr_ptr wins.
            for (int unsigned k = N_CH; k > 0; k--) begin
                rr_idx = 32'(rr_ptr) + k;
                if (rr_idx >= N_CH) begin
                    rr_idx = rr_idx - N_CH;
                end
                if (1'(in_valid >> rr_idx)) begin
                    grant_ok = 1'b1;
                    grant_ch = SW'(rr_idx);
                end
            end
        end
`endif
    end

    assign grant_data = DW'(in_data >> (32'(grant_ch) * DW));
    assign space      = !out_valid || out_ready;
    assign take       = grant_ok && space && rst_n;
    assign in_ready   = take ? (N_CH'(1) << grant_ch) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            xfer_cnt  <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr    <= SW'(N_CH - 1);
`endif
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_ch;
            if (xfer_cnt != '1) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
`ifdef STREAM_MUX_RR_EN
            if (rr_en) begin
                rr_ptr <= grant_ch;
            end
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
